// File: rtl/median_window_filter_if.sv
// Column-in / rank-out stream bundle for median_window_filter.
interface median_window_filter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WINDOW     = 7
);
    logic                         in_valid;
    logic [1:0]                   in_mode;
    logic [WINDOW*DATA_WIDTH-1:0] in_col;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out;

    modport master (output in_valid, in_mode, in_col, input out_valid, out);
    modport slave  (input in_valid, in_mode, in_col, output out_valid, out);
endinterface

// File: rtl/median_window_filter.sv
// Streaming WINDOW x WINDOW rank filter: each column is sorted and ranked, the last
// WINDOW column ranks are kept as a history, and that history is sorted and ranked again.
module median_window_filter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WINDOW     = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    median_window_filter_if.slave bus
);
    localparam int unsigned MID = (WINDOW - 1) / 2;
    localparam int unsigned CW  = $clog2(WINDOW + 1);

    typedef logic [WINDOW-1:0][DATA_WIDTH-1:0] col_t;
    typedef logic [WINDOW-2:0][DATA_WIDTH-1:0] hist_t;

    if ((WINDOW % 2 == 0) || (WINDOW < 3) || (WINDOW > 15)) begin : g_bad_window
        $error("median_window_filter: WINDOW must be odd and within 3..15");
    end

    // Pick the ranked element out of an ascending-sorted vector.
    function automatic logic [DATA_WIDTH-1:0] rank_sel(input col_t c, input logic [1:0] m);
        case (m)
            2'd1:    rank_sel = c[0];
            2'd2:    rank_sel = c[WINDOW-1];
            default: rank_sel = c[MID];
        endcase
    endfunction

    logic                  w_clr;
    col_t                  r_a  [0:WINDOW];
    logic                  r_av [0:WINDOW];
    logic [1:0]            r_am [0:WINDOW];
    col_t                  r_b  [0:WINDOW];
    logic                  r_bv [0:WINDOW];
    logic [1:0]            r_bm [0:WINDOW];
    col_t                  w_a_nx [0:WINDOW-1];
    col_t                  w_b_nx [0:WINDOW-1];
    hist_t                 r_hist;
    logic [CW-1:0]         r_fill;
    logic [CW-1:0]         w_fill_nx;
    col_t                  w_hist_nx;
    logic [DATA_WIDTH-1:0] w_a_sel;
    logic [DATA_WIDTH-1:0] w_b_sel;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out;

    assign w_clr = rst | refresh;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_av[0] <= 1'b0;
            r_a[0]  <= '0;
            r_am[0] <= '0;
        end else begin
            r_av[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_a[0]  <= bus.in_col;
                r_am[0] <= bus.in_mode;
            end
        end
    end

    // Odd-even transposition: stage s compare-exchanges pairs starting at index s%2.
    for (genvar s = 0; s < WINDOW; s++) begin : g_stage
        for (genvar i = 0; i < WINDOW; i++) begin : g_elem
            if ((i % 2 == s % 2) && (i + 1 < WINDOW)) begin : g_lo
                assign w_a_nx[s][i] = (r_a[s][i] <= r_a[s][i+1]) ? r_a[s][i] : r_a[s][i+1];
                assign w_b_nx[s][i] = (r_b[s][i] <= r_b[s][i+1]) ? r_b[s][i] : r_b[s][i+1];
            end else if ((i % 2 != s % 2) && (i > 0)) begin : g_hi
                assign w_a_nx[s][i] = (r_a[s][i-1] <= r_a[s][i]) ? r_a[s][i] : r_a[s][i-1];
                assign w_b_nx[s][i] = (r_b[s][i-1] <= r_b[s][i]) ? r_b[s][i] : r_b[s][i-1];
            end else begin : g_pass
                assign w_a_nx[s][i] = r_a[s][i];
                assign w_b_nx[s][i] = r_b[s][i];
            end
        end

        always_ff @(posedge clk) begin
            if (w_clr) begin
                r_a[s+1]  <= '0;
                r_av[s+1] <= 1'b0;
                r_am[s+1] <= '0;
                r_b[s+1]  <= '0;
                r_bv[s+1] <= 1'b0;
                r_bm[s+1] <= '0;
            end else begin
                r_a[s+1]  <= w_a_nx[s];
                r_av[s+1] <= r_av[s];
                r_am[s+1] <= r_am[s];
                r_b[s+1]  <= w_b_nx[s];
                r_bv[s+1] <= r_bv[s];
                r_bm[s+1] <= r_bm[s];
            end
        end
    end

    // Entry WINDOW-1 is never needed: it is the one discarded by the next push.
    assign w_a_sel   = rank_sel(r_a[WINDOW], r_am[WINDOW]);
    assign w_hist_nx = {r_hist, w_a_sel};
    assign w_fill_nx = (r_fill == CW'(WINDOW)) ? r_fill : r_fill + CW'(1);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_b[0]  <= '0;
            r_bv[0] <= 1'b0;
            r_bm[0] <= '0;
        end else begin
            r_bv[0] <= 1'b0;
            if (r_av[WINDOW]) begin
                r_hist  <= w_hist_nx[WINDOW-2:0];
                r_fill  <= w_fill_nx;
                r_b[0]  <= w_hist_nx;
                r_bm[0] <= r_am[WINDOW];
                r_bv[0] <= (w_fill_nx == CW'(WINDOW));
            end
        end
    end

    assign w_b_sel = rank_sel(r_b[WINDOW], r_bm[WINDOW]);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_out_valid <= r_bv[WINDOW];
            if (r_bv[WINDOW]) begin
                r_out <= w_b_sel;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
endmodule

// File: tb/tb_median_window_filter.sv
// Scoreboard bench for median_window_filter: a queue-based rank model predicts each
// window result and its arrival cycle; a negedge monitor pops and compares.
module tb_median_window_filter;
    localparam int unsigned DW  = 8;
    localparam int unsigned W   = 7;
    localparam int unsigned LAT = 2 * W + 2;

    logic clk = 1'b0;
    logic rst;
    logic refresh;

    median_window_filter_if #(.DATA_WIDTH(DW), .WINDOW(W)) bus ();
    median_window_filter #(.DATA_WIDTH(DW), .WINDOW(W)) dut (
        .clk(clk), .rst(rst), .refresh(refresh), .bus(bus)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    int     exp_val_q[$];
    longint exp_cyc_q[$];
    int     obs_q[$];
    int     hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            obs_q.push_back(int'(bus.out));
            if (exp_val_q.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                check("out value", longint'(bus.out), longint'(exp_val_q.pop_front()));
                check("out latency", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    function automatic int rank_of(input int v[$], input logic [1:0] m);
        int s[$];
        s = v;
        s.sort();
        case (m)
            2'd1:    return s[0];
            2'd2:    return s[s.size()-1];
            default: return s[(s.size()-1)/2];
        endcase
    endfunction

    function automatic logic [W*DW-1:0] col_all(input int v);
        logic [W*DW-1:0] c;
        for (int k = 0; k < W; k++) c[k*DW +: DW] = DW'(v);
        return c;
    endfunction

    function automatic logic [W*DW-1:0] col_seq();
        logic [W*DW-1:0] c;
        for (int k = 0; k < W; k++) c[k*DW +: DW] = DW'(k);
        return c;
    endfunction

    function automatic logic [W*DW-1:0] col_rand();
        logic [W*DW-1:0] c;
        for (int k = 0; k < W; k++) c[k*DW +: DW] = DW'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic model_clear();
        hist.delete();
        exp_val_q.delete();
        exp_cyc_q.delete();
    endtask

    // Present one beat for one edge; clr also raises refresh in that same cycle.
    task automatic beat(input logic [W*DW-1:0] col, input logic [1:0] mode, input bit clr);
        int px[$];
        bus.in_valid = 1'b1;
        bus.in_col   = col;
        bus.in_mode  = mode;
        refresh      = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            model_clear();
        end else begin
            for (int k = 0; k < W; k++) px.push_back(int'(col[k*DW +: DW]));
            hist.push_front(rank_of(px, mode));
            if (hist.size() > W) void'(hist.pop_back());
            if (hist.size() == W) begin
                exp_val_q.push_back(rank_of(hist, mode));
                exp_cyc_q.push_back(cyc + LAT);
            end
        end
        bus.in_valid = 1'b0;
        refresh      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_refresh();
        refresh = 1'b1;
        @(posedge clk);
        #1;
        refresh = 1'b0;
        model_clear();
        obs_q.delete();
    endtask

    task automatic expect_obs(input string name, input int e[$]);
        check({name, " count"}, obs_q.size(), e.size());
        for (int k = 0; k < e.size() && k < obs_q.size(); k++) check(name, obs_q[k], e[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int              e[$];
        logic [W*DW-1:0] c;

        rst          = 1'b1;
        refresh      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'd0;
        bus.in_col   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out", longint'(bus.out), 0);
        check("reset out_valid", longint'(bus.out_valid), 0);

        repeat (40) begin
            @(negedge clk);
            check("idle out", longint'(bus.out), 0);
            check("idle out_valid", longint'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Ramp 10..80 back-to-back.
        obs_q.delete();
        for (int j = 0; j < 8; j++) beat(col_all(10 * (j + 1)), 2'd0, 1'b0);
        idle(LAT + 4);
        e = {40, 50};
        expect_obs("ramp", e);

        // Same ramp with idle gaps.
        do_refresh();
        for (int j = 0; j < 8; j++) begin
            beat(col_all(10 * (j + 1)), 2'd0, 1'b0);
            idle($urandom_range(1, 3));
        end
        idle(LAT + 4);
        e = {40, 50};
        expect_obs("ramp gaps", e);

        // Mode selection over a 0..6 column.
        for (int m = 0; m < 3; m++) begin
            do_refresh();
            for (int j = 0; j < 7; j++) beat(col_seq(), 2'(m), 1'b0);
            idle(LAT + 4);
            e = {(m == 0) ? 3 : ((m == 1) ? 0 : 6)};
            expect_obs("mode rank", e);
        end

        // Impulse rejection.
        do_refresh();
        c = col_all(5);
        c[3*DW +: DW] = 8'd255;
        for (int j = 0; j < 7; j++) beat(c, 2'd0, 1'b0);
        c = col_all(5);
        c[0 +: DW] = 8'd0;
        beat(c, 2'd0, 1'b0);
        idle(LAT + 4);
        e = {5, 5};
        expect_obs("impulse", e);

        // Refresh mid-stream, coincident with a valid beat.
        do_refresh();
        for (int j = 0; j < 5; j++) beat(col_rand(), 2'd0, 1'b0);
        beat(col_rand(), 2'd0, 1'b1);
        for (int j = 0; j < 7; j++) beat(col_all(9), 2'd0, 1'b0);
        idle(LAT + 4);
        e = {9};
        expect_obs("refresh refill", e);

        // Random columns, modes, gaps and occasional refresh.
        do_refresh();
        for (int j = 0; j < 150; j++) begin
            beat(col_rand(), 2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(LAT + 4);
        check("scoreboard drained", exp_val_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/median_window_filter.md
Name: median_window_filter

Overview:
- Streaming 2-D rank filter over a WINDOW x WINDOW pixel window. One column of WINDOW pixels arrives per accepted beat.
- Stage A reduces each column to a rank value (median, min or max) through a pipelined odd-even transposition sort.
- Stage B keeps a shift history of the last WINDOW column results and reduces it the same way.
- Parametrised successor of the fixed 7x7 median-of-medians filter. Adds valid qualification, fill tracking, idle-cycle tolerance and min/max modes.

Parameters:
- DATA_WIDTH, 8, bits per pixel, unsigned.
- WINDOW, 7, window size. Must be odd, 3..15; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- refresh  in  1  synchronous clear, same effect as rst (frame/line restart).
- in_valid  in  1  column beat valid; no backpressure, every valid beat is accepted.
- in_mode  in  2  0 = median, 1 = min, 2 = max, 3 = treated as median. Sampled with the column.
- in_col  in  WINDOW*DATA_WIDTH  column pixels; element k = in_col[k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out holds a new window result this cycle.
- out  out  DATA_WIDTH  window result, registered.

Behaviour:
- Reset/refresh (either high at an edge):
  - out=0, out_valid=0.
  - All pipeline valid bits=0, history entries=0, fill count=0.
  - A beat presented in the same cycle is dropped; rst/refresh wins.
- Input register: on in_valid, captures in_col and in_mode and sets v0. Otherwise v0=0.
- Stage A (column sort): WINDOW registered compare-exchange stages, odd-even transposition, ascending unsigned.
  - Valid bit and mode travel with the data.
  - Selected element: index (WINDOW-1)/2 for median, 0 for min, WINDOW-1 for max.
- History push: when the stage-A valid bit is set, history shifts by one. Newest result goes to entry 0; entry WINDOW-1 is discarded.
  - Fill count increments, saturating at WINDOW.
  - With valid clear: history and count hold (idle cycles are transparent).
  - The push forwards a snapshot of all WINDOW entries, plus the beat's mode, to stage B. The snapshot is valid only if the post-push count == WINDOW.
- Stage B (history sort): same WINDOW-stage registered sort and rank selection, using the mode carried from the newest beat.
- Output register: out <= stage-B result and out_valid <= 1 when the stage-B valid bit is set. Otherwise out holds its last value and out_valid=0.
- Latency: fixed L = 2*WINDOW+2 edges from acceptance edge to out_valid (16 for WINDOW=7).
- Throughput: one result per accepted beat once full. Back-to-back beats are fully pipelined.
- Mixed modes: each history entry keeps the value selected under its own beat's mode. Stage B applies only the newest mode. No re-evaluation of old entries.
- Fill boundary:
  - The first WINDOW-1 accepted beats after reset/refresh produce no out_valid.
  - Beat WINDOW (index WINDOW-1) produces the first result.
- Refresh mid-stream: in-flight beats are discarded and no out_valid pulse occurs from them. Refill needs WINDOW new beats.
- Equal values: the sort is stable in effect (ties are irrelevant to output value).

Test Plan (WINDOW=7, DATA_WIDTH=8, L=16):
1. rst held 3 cycles, then idle 40 cycles -> out=0, out_valid=0 throughout.
2. Seven back-to-back beats, column j all pixels 10*(j+1) (10..70), mode 0:
   - out_valid first high exactly 16 cycles after the 7th acceptance edge, with out=40.
   - An 8th beat (all 80) gives out=50 one cycle later.
3. Same stream as scenario 2, with 1-3 idle cycles between beats -> identical out sequence (40, 50). Exactly one out_valid pulse per accepted beat after fill.
4. Seven beats each with column {0,1,2,3,4,5,6}:
   - mode 0 -> out=3.
   - mode 1 -> out=0.
   - mode 2 -> out=6.
5. Seven beats with column {5,5,5,255,5,5,5}, plus one beat with {0,5,5,5,5,5,5}, mode 0 -> out=5 for both results (impulse rejection).
6. Five beats, then refresh together with a 6th valid beat, then seven beats of all 9:
   - No out_valid from the pre-refresh beats.
   - First out_valid 16 cycles after the 7th new beat, with out=9.
